alu_issue_stage: RTL
====================

Name: alu_issue_stage

Overview:
- Execute-stage issuer for the 32-bit gate-level ALU; drives that ALU's a, b and 3-bit m select and consumes its result.
- Holds an ID/EX register (S1) and an EX/MEM register (S2) with valid/ready handshakes on both sides.
- Decodes a 4-bit pipeline opcode into the ALU m encoding.
- Sits between the decode stage and the memory stage of the 5-stage pipeline.

Parameters:
DATA_W, 32, operand/result width; must equal the ALU width.
REG_W, 5, register-specifier width.

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous, active-high reset
in_valid  input  1  decode stage offers an instruction
in_ready  output  1  S1 can accept this cycle
in_op  input  4  0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 NOR, 6 NAND, 7 SLT, 8-15 illegal
in_a  input  DATA_W  rs operand value
in_b  input  DATA_W  rt operand value
in_rs  input  REG_W  rs specifier
in_rt  input  REG_W  rt specifier
in_rd  input  REG_W  destination specifier
alu_a  output  DATA_W  ALU operand a
alu_b  output  DATA_W  ALU operand b
alu_m  output  3  ALU select
alu_result  input  DATA_W  combinational ALU result
out_valid  output  1  S2 holds a result
out_ready  input  1  memory stage accepts
out_result  output  DATA_W  S2 result
out_rd  output  REG_W  S2 destination
out_illegal  output  1  S2 instruction had an illegal opcode
out_zero  output  1  out_result == 0

Behaviour:
- m decode, combinational from the S1 opcode: ADD 3'b011, SUB 3'b111, SLT 3'b110, OR 3'b000, AND 3'b001, XOR 3'b010, NOR 3'b100, NAND 3'b101. Illegal opcodes give 3'b011 and set the illegal bit in S1.
- SLT result is {31'b0, sign bit of a-b}. No overflow correction; this is the ALU's own behaviour and is passed through unchanged.
- alu_a, alu_b and alu_m are driven combinationally from S1, after forwarding. When S1 is empty they still reflect the S1 registers.
- s2_load = s1_valid && (!s2_valid || out_ready).
- s1_load = in_valid && in_ready, where in_ready = !s1_valid || s2_load. This is a combinational ready chain; there are no bubbles at full throughput.
- Latency: an instruction accepted at edge k is in S1 after edge k and in S2 (out_valid=1) after edge k+1. Throughput is 1 per cycle.
- S2 loads alu_result, rd and the illegal bit. For an illegal opcode out_result is forced to 0.
- out_valid clears on (out_valid && out_ready && !s2_load).
- Simultaneous drain and load of S2 keeps out_valid=1 with the new contents.
- S2 contents are stable while out_valid && !out_ready.
- S1 contents are stable while s1_valid && !s2_load. in_* is ignored when in_ready=0.
- Last-result record (lr_valid, lr_rd, lr_result) is written on every s2_load with the loaded rd/result. It is not cleared by a drain, so it always holds the instruction immediately older than S1.
- Reset, asynchronous and mid-operation included: s1_valid=0, out_valid=0, lr_valid=0, all data/rd/op registers 0, out_illegal=0.
  - With S1 cleared, alu_m=3'b011 and alu_a=alu_b=0.
  - in_ready=1 and out_zero=1 (out_result 0).
  - In-flight instructions are discarded. The first cycle after deassertion accepts normally.

Optional Feature:
- Macro EX_FWD_EN.
- Defined: when lr_valid && lr_rd != 0:
  - alu_a uses lr_result if S1 rs == lr_rd.
  - alu_b uses lr_result if S1 rt == lr_rd.
  - Both operands may forward at the same time.
  - Illegal-opcode records (result 0) still forward 0.
- Undefined: alu_a/alu_b always come from the S1 operand registers, and the lr_* record is not built.

Test Plan:
- Reset, then ADD a=5 b=7 rd=3 with out_ready=1 -> alu_m=011; out_valid two edges after accept with out_result=12, out_rd=3, out_zero=0.
- SUB 5-7, then SLT 5,7, then SLT 7,5 back-to-back -> results 0xFFFFFFFE, 1, 0; one result per cycle, in_ready constantly 1.
- AND/OR/XOR/NOR/NAND with a=0xF0F0F0F0, b=0xFF00FF00 -> 0xF000F000, 0xFFF0FFF0, 0x0FF00FF0, 0x000F000F, 0x0FFF0FFF; m=001/000/010/100/101.
- Hold out_ready=0 for 4 cycles with 3 instructions offered -> S2 and S1 fill and in_ready=0 after the 2nd accept; out_result stable; release gives in-order delivery with none lost or duplicated.
- in_op=9, a=1, b=1 -> alu_m=011, out_illegal=1, out_result=0, out_zero=1.
- With EX_FWD_EN: ADD rd=4 (1+2), then SUB rs=4 rt=4 with stale operands 9,9 -> second result 0. A forward to rd=0 is ignored. Asserting rst while both stages are valid -> out_valid=0 and in_ready=1 immediately.

Source files
------------

// File: rtl/alu_issue_stage.sv
// Execute-stage issuer: ID/EX (S1) and EX/MEM (S2) registers around the external 32-bit ALU.
// Optional macro EX_FWD_EN adds forwarding from the last-result record into the ALU operands.
module alu_issue_stage #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned REG_W  = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        in_op,
    input  logic [DATA_W-1:0] in_a,
    input  logic [DATA_W-1:0] in_b,
    input  logic [REG_W-1:0]  in_rs,
    input  logic [REG_W-1:0]  in_rt,
    input  logic [REG_W-1:0]  in_rd,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [2:0]        alu_m,
    input  logic [DATA_W-1:0] alu_result,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_result,
    output logic [REG_W-1:0]  out_rd,
    output logic              out_illegal,
    output logic              out_zero
);

    logic              s1_valid_q;
    logic [3:0]        s1_op_q;
    logic [DATA_W-1:0] s1_a_q;
    logic [DATA_W-1:0] s1_b_q;
    logic [REG_W-1:0]  s1_rd_q;
    logic              s1_illegal_q;

    logic              s2_valid_q;
    logic [DATA_W-1:0] s2_result_q;
    logic [REG_W-1:0]  s2_rd_q;
    logic              s2_illegal_q;

    logic              s1_load;
    logic              s2_load;
    logic [DATA_W-1:0] s2_data;

    // Combinational ready chain: S1 may refill in the same cycle it hands off to S2.
    assign s2_load  = s1_valid_q && (!s2_valid_q || out_ready);
    assign in_ready = !s1_valid_q || s2_load;
    assign s1_load  = in_valid && in_ready;

    always_comb begin
        alu_m = 3'b011;
        case (s1_op_q)
            4'd0:    alu_m = 3'b011;
            4'd1:    alu_m = 3'b111;
            4'd2:    alu_m = 3'b001;
            4'd3:    alu_m = 3'b000;
            4'd4:    alu_m = 3'b010;
            4'd5:    alu_m = 3'b100;
            4'd6:    alu_m = 3'b101;
            4'd7:    alu_m = 3'b110;
            default: alu_m = 3'b011;
        endcase
    end

    assign s2_data = s1_illegal_q ? '0 : alu_result;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_q   <= 1'b0;
            s1_op_q      <= '0;
            s1_a_q       <= '0;
            s1_b_q       <= '0;
            s1_rd_q      <= '0;
            s1_illegal_q <= 1'b0;
        end else begin
            if (s1_load) begin
                s1_valid_q   <= 1'b1;
                s1_op_q      <= in_op;
                s1_a_q       <= in_a;
                s1_b_q       <= in_b;
                s1_rd_q      <= in_rd;
                s1_illegal_q <= in_op[3];
            end else if (s2_load) begin
                s1_valid_q <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s2_valid_q   <= 1'b0;
            s2_result_q  <= '0;
            s2_rd_q      <= '0;
            s2_illegal_q <= 1'b0;
        end else begin
            if (s2_load) begin
                s2_valid_q   <= 1'b1;
                s2_result_q  <= s2_data;
                s2_rd_q      <= s1_rd_q;
                s2_illegal_q <= s1_illegal_q;
            end else if (out_ready) begin
                s2_valid_q <= 1'b0;
            end
        end
    end

`ifdef EX_FWD_EN
    logic [REG_W-1:0]  s1_rs_q;
    logic [REG_W-1:0]  s1_rt_q;
    logic              lr_valid_q;
    logic [REG_W-1:0]  lr_rd_q;
    logic [DATA_W-1:0] lr_result_q;
    logic              lr_hit_ok;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_rs_q <= '0;
            s1_rt_q <= '0;
        end else if (s1_load) begin
            s1_rs_q <= in_rs;
            s1_rt_q <= in_rt;
        end
    end

    // Not cleared on drain: always the instruction just older than S1.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lr_valid_q  <= 1'b0;
            lr_rd_q     <= '0;
            lr_result_q <= '0;
        end else if (s2_load) begin
            lr_valid_q  <= 1'b1;
            lr_rd_q     <= s1_rd_q;
            lr_result_q <= s2_data;
        end
    end

    assign lr_hit_ok = lr_valid_q && (lr_rd_q != '0);

    always_comb begin
        alu_a = s1_a_q;
        alu_b = s1_b_q;
        if (lr_hit_ok && (s1_rs_q == lr_rd_q)) alu_a = lr_result_q;
        if (lr_hit_ok && (s1_rt_q == lr_rd_q)) alu_b = lr_result_q;
    end
`else
    logic unused_fwd;
    assign unused_fwd = ^{in_rs, in_rt};

    assign alu_a = s1_a_q;
    assign alu_b = s1_b_q;
`endif

    assign out_valid   = s2_valid_q;
    assign out_result  = s2_result_q;
    assign out_rd      = s2_rd_q;
    assign out_illegal = s2_illegal_q;
    assign out_zero    = (s2_result_q == '0);

endmodule
